// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX module among N_REQ byte requesters.
// Optional SEND watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] Req_Data,
  output logic [N_REQ-1:0]   Ack,
  output logic [N_REQ-1:0]   Done,
  output logic               Busy,
  output logic               Err,
  input  logic               TX_Done_Sig,
  output logic               TX_En_Sig,
  output logic [7:0]         TX_Data
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC == 20'd0) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    last_q, last_nx;
  logic [IW-1:0]    win_q, win_nx;
  logic [IW-1:0]    pick;
  logic             found;
  logic             tx_en_q, tx_en_nx;
  logic [7:0]       tx_data_q, tx_data_nx;
  logic [N_REQ-1:0] ack_q, ack_nx;
  logic [N_REQ-1:0] done_q, done_nx;
  logic             timeout;

`ifdef UART_ARB_TIMEOUT_EN
  logic [19:0]      tmr_q, tmr_nx;
  logic             err_q, err_nx;

  assign timeout = (tmr_q == TIMEOUT_CYC - 20'd1);
  assign Err     = err_q;
`else
  assign timeout = 1'b0;
  assign Err     = 1'b0;
`endif

  // Search upward from last+1 with wrap; the first set bit wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = 32'(last_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && Req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last_q;
    win_nx     = win_q;
    tx_en_nx   = tx_en_q;
    tx_data_nx = tx_data_q;
    ack_nx     = '0;
    done_nx    = '0;
`ifdef UART_ARB_TIMEOUT_EN
    tmr_nx     = tmr_q;
    err_nx     = err_q;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_nx   = Req_Data[8*pick +: 8];
          ack_nx[pick] = 1'b1;
          tx_en_nx     = 1'b1;
          win_nx       = pick;
          state_nx     = SEND;
`ifdef UART_ARB_TIMEOUT_EN
          tmr_nx       = '0;
`endif
        end
      end
      SEND: begin
        // A completion on the same edge as the watchdog limit is a normal finish.
        if (TX_Done_Sig || timeout) begin
          tx_en_nx      = 1'b0;
          done_nx[win_q] = 1'b1;
          last_nx       = win_q;
          state_nx      = GAP;
`ifdef UART_ARB_TIMEOUT_EN
          if (!TX_Done_Sig) err_nx = 1'b1;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
          tmr_nx = tmr_q + 20'd1;
`endif
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      last_q    <= IW'(N_REQ - 1);
      win_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      ack_q     <= '0;
      done_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      tmr_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      last_q    <= last_nx;
      win_q     <= win_nx;
      tx_en_q   <= tx_en_nx;
      tx_data_q <= tx_data_nx;
      ack_q     <= ack_nx;
      done_q    <= done_nx;
`ifdef UART_ARB_TIMEOUT_EN
      tmr_q     <= tmr_nx;
      err_q     <= err_nx;
`endif
    end
  end

  assign Ack       = ack_q;
  assign Done      = done_q;
  assign TX_En_Sig = tx_en_q;
  assign TX_Data   = tx_data_q;
  assign Busy      = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit module among up to N_REQ byte requesters. Round-robin arbitration picks one pending requester, loads its byte onto the transmitter's enable/data inputs, holds them until the transmitter reports completion, then returns a per-requester completion pulse. It sits between the application control blocks and the UART TX module, and replaces a one-second self-timed trigger with demand-driven, fair access.

## Interface
- N_REQ, 4: number of requesters, legal range 2..8.
- TIMEOUT_CYC, 20'd1_000_000: SEND-state watchdog limit in CLK cycles (20 ms at 50 MHz). Used only when the watchdog macro is defined.

Ports:
- CLK  in  1  system clock (50 MHz).
- RSTn  in  1  asynchronous, active-low reset.
- Req  in  N_REQ  level request per requester.
- Req_Data  in  8*N_REQ  byte for requester i on bits [8i+7:8i].
- Ack  out  N_REQ  one-hot, one-cycle pulse; the byte of requester i is captured.
- Done  out  N_REQ  one-hot, one-cycle pulse; the byte of requester i has finished transmitting.
- Busy  out  1  high in every state except IDLE.
- Err  out  1  sticky watchdog error flag.
- TX_Done_Sig  in  1  completion pulse from the UART TX module.
- TX_En_Sig  out  1  transmit enable to the UART TX module, registered.
- TX_Data  out  8  byte to the UART TX module, registered.

## Operation
- FSM states: IDLE, SEND, GAP. Reset state is IDLE.
- IDLE:
  - If any Req bit is high, grant the first set bit searching upward from (last+1) mod N_REQ, with wrap.
  - On the granting edge: capture Req_Data of the winner into TX_Data, pulse Ack[winner], set TX_En_Sig=1, store the winner index, go to SEND.
- SEND:
  - Hold TX_En_Sig=1 and TX_Data constant.
  - On TX_Done_Sig: clear TX_En_Sig, pulse Done[winner], set last=winner, go to GAP.
- GAP: one cycle with TX_En_Sig=0, so the TX module observes enable low. Then go to IDLE.
- Req is sampled only in IDLE. Req and Req_Data changes during SEND or GAP are ignored.
- A requester must hold Req and its byte stable until Ack.
- Req still high after Ack counts as a new request. It is arbitrated in the next IDLE, so others get a turn first.
- TX_Done_Sig outside SEND is ignored.
- Reset values:
  - TX_En_Sig=0, TX_Data=8'h00, Ack=0, Done=0, Busy=0, Err=0.
  - last=N_REQ-1, so requester 0 has top priority after reset.
- Asserting RSTn low mid-transfer aborts immediately: TX_En_Sig drops and no Done pulse is issued.
- Unused Req_Data bits do not matter. Req bits for indices at or above N_REQ do not exist.

## Timing
- Req seen high in IDLE at edge k: Ack pulse, TX_En_Sig=1, TX_Data valid, and Busy=1 all appear after edge k.
- TX_Done_Sig high at edge m: TX_En_Sig=0 and Done pulse after edge m. The FSM is in GAP for that cycle and in IDLE after edge m+1.
- Back-to-back transfers:
  - The earliest next TX_En_Sig rise is after edge m+2.
  - TX_En_Sig is low for at least 2 cycles between bytes.
- Ack and Done each last exactly one cycle and are never asserted for two requesters at once.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A 20-bit counter clears when SEND is entered and increments every SEND cycle.
  - When it reaches TIMEOUT_CYC without TX_Done_Sig: TX_En_Sig=0, Done[winner] pulses, Err=1 (sticky until RSTn), go to GAP.
  - If TX_Done_Sig arrives on the same edge as the limit, treat it as normal completion: Err stays unchanged.
- UART_ARB_TIMEOUT_EN undefined: no counter, SEND waits indefinitely, Err is tied 0, TIMEOUT_CYC is unused.

## Test plan
- Single request: Req=4'b0100 with byte 8'h31 -> Ack=4'b0100 on the next cycle, TX_Data=8'h31, TX_En_Sig stays high until TX_Done_Sig, then Done=4'b0100 for one cycle and Busy low 2 cycles later.
- All requesters held high from reset, bytes 8'hA0..8'hA3 -> grant order 0,1,2,3,0 with TX_Data following; TX_En_Sig low ≥2 cycles between bytes.
- Req_Data changed during SEND -> TX_Data unchanged until the next grant.
- RSTn pulsed low mid-SEND -> TX_En_Sig=0 and TX_Data=8'h00 immediately, no Done; the next grant goes to requester 0 if it is requesting.
- Spurious TX_Done_Sig in IDLE -> no Done and no state change.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=20'd100, no TX_Done_Sig -> TX_En_Sig drops 100 cycles after entering SEND, Done pulses, Err=1 and stays high.
